imem_boot_sequencer: RTL
========================

# imem_boot_sequencer

Boot and run controller placed around the single-cycle processor core. It holds the core in reset, streams a program into instruction memory through a valid/ready handshake, and releases the core. It then supervises execution until a halt instruction is fetched or a cycle budget expires, and freezes the core again in a reported final state.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 8, instruction-memory word-address width (capacity 2^ADDR_WIDTH words)
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding treated as halt
- CNT_WIDTH, 16, width of Run_Cycles and Run_Count

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-low
- Start  in  1  begin load sequence (sampled in IDLE and HALT only)
- Abort  in  1  return to IDLE from LOAD/RELEASE/RUN
- Run_Cycles  in  CNT_WIDTH  run budget in cycles, 0 = unlimited; latched when Start is accepted
- Load_Valid  in  1  Load_Data valid
- Load_Data  in  DATA_WIDTH  program word
- Load_Last  in  1  marks final program word
- Load_Ready  out  1  sequencer accepts a word this cycle
- IMem_WE  out  1  instruction-memory write enable
- IMem_Addr  out  ADDR_WIDTH  write word address
- IMem_WData  out  DATA_WIDTH  write data
- Core_RST  out  1  core reset, active-low, registered
- Core_Instruction  in  DATA_WIDTH  instruction currently fetched by the core
- Busy  out  1  high in LOAD, RELEASE, RUN
- Done  out  1  high in HALT
- Halted  out  1  run ended on HALT_INSTR
- Timeout  out  1  run ended on budget
- Word_Count  out  ADDR_WIDTH+1  words written in the current load
- Run_Count  out  CNT_WIDTH  cycles spent in RUN

## Operation
- States: IDLE, LOAD, RELEASE, RUN, HALT.
- Reset (RST=0 at an edge):
  - State is IDLE. Core_RST=0.
  - Load_Ready, Busy, Done, Halted, Timeout are 0. Word_Count and Run_Count are 0.
  - Latched budget is 0.
- IDLE:
  - Core_RST=0.
  - Start=1 → LOAD. Clears Word_Count, Run_Count, Halted, Timeout. Latches Run_Cycles.
- LOAD:
  - Load_Ready=1 (combinational from state).
  - Accept = Load_Valid & Load_Ready.
  - IMem_WE = Accept, IMem_Addr = Word_Count[ADDR_WIDTH-1:0], IMem_WData = Load_Data. All combinational.
  - Each accept increments Word_Count.
  - Accept with Load_Last=1, or accept at address 2^ADDR_WIDTH-1 → RELEASE. Further words are not accepted.
- RELEASE:
  - Lasts exactly one cycle with Core_RST=0, then → RUN.
  - Core_RST register is set to 1 on that transition edge.
- RUN:
  - Core_RST=1. Run_Count increments every RUN cycle, saturating at all-ones.
  - Core_Instruction==HALT_INSTR → HALT, Halted=1.
  - Otherwise, if budget≠0 and Run_Count==budget-1 → HALT, Timeout=1.
  - Both conditions in the same cycle: Halted=1, Timeout=0.
- HALT:
  - Core_RST=0, Done=1, Busy=0. Flags and counts are held.
  - Start=1 → LOAD, with the same clears as from IDLE.
- Abort=1 in LOAD, RELEASE or RUN → IDLE next edge, with Core_RST=0, Done=0.
  - Counts and flags are held; Start clears them.
  - Abort has priority over all other transitions.
  - Abort in IDLE or HALT is ignored.
- Outside LOAD: IMem_WE=0, Load_Ready=0.
- Start is ignored in LOAD, RELEASE and RUN.
- RST=0 in any state forces reset values at that edge. Core_RST drops to 0 at the same edge.

## Timing
- Start at edge N → LOAD visible after N; Load_Ready=1 in cycle N+1.
- Word write happens in the same cycle as the accept. Zero added latency.
- Load_Valid gaps: no write, no count change.
- Last accept in cycle K → RELEASE in K+1, RUN (Core_RST=1) from K+2.
- RUN length:
  - Timeout: exactly budget cycles.
  - Halt: RUN includes the cycle that presented HALT_INSTR.
- Core_RST returns to 0 on the edge ending the final RUN cycle.
- Done/Halted/Timeout are valid from the first HALT cycle.

## Test plan
- Reset: hold RST=0 2 cycles, then release. All outputs are 0 (Core_RST=0), state IDLE; Start=0 keeps IDLE.
- Normal boot:
  - Stimulus: Start with Run_Cycles=0. Stream 4 words at full rate; word 3 = 32'hFFFF_FFFF with Last.
  - Response: IMem writes addr 0..3, Word_Count=4, one RELEASE cycle, Core_RST=1.
  - Sequential fetch of 4 words → Halted=1, Timeout=0, Run_Count=4, Done=1.
- Timeout:
  - Stimulus: load 2 non-halt words plus a branch-to-self (no halt); Run_Cycles=10.
  - Response: RUN lasts 10 cycles, Timeout=1, Run_Count=10, Core_RST=0 afterwards.
- Backpressure/gaps: Load_Valid toggles 1,0,0,1,1 with Last on the final word. Writes occur only on valid cycles at addresses 0,1,2; Word_Count=3.
- Overflow with ADDR_WIDTH=3: stream 10 words, no Last.
  - Writes occur at addresses 0..7 only. Load_Ready=0 from the cycle after the 8th accept.
  - Word_Count=8; RELEASE follows.
- Abort and priority:
  - Abort in cycle 3 of RUN → IDLE next edge, Core_RST=0, Done=0.
  - Separate run with Run_Cycles=3 and HALT_INSTR fetched in RUN cycle 3 → Halted=1, Timeout=0.

Source files
------------

// File: rtl/imem_boot_sequencer.sv
// Boot/run controller wrapped around the single-cycle core.
// It holds the core in reset and streams a program into instruction memory.
// It then releases the core and supervises the run until the core fetches a
// halt instruction or the cycle budget expires. After that it freezes the
// core again and reports why the run ended.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | core held in reset, waiting for Start
// LOAD    | accepting program words, writing them to instruction memory
// RELEASE | one settling cycle before the core is let out of reset
// RUN     | core executing, run counter advancing, halt/budget watched
// HALT    | core frozen, Done with Halted/Timeout reporting the cause
module imem_boot_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = {DATA_WIDTH{1'b1}},
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [CNT_WIDTH-1:0]  Run_Cycles,
  input  logic                  Load_Valid,
  input  logic [DATA_WIDTH-1:0] Load_Data,
  input  logic                  Load_Last,
  output logic                  Load_Ready,
  output logic                  IMem_WE,
  output logic [ADDR_WIDTH-1:0] IMem_Addr,
  output logic [DATA_WIDTH-1:0] IMem_WData,
  output logic                  Core_RST,
  input  logic [DATA_WIDTH-1:0] Core_Instruction,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Halted,
  output logic                  Timeout,
  output logic [ADDR_WIDTH:0]   Word_Count,
  output logic [CNT_WIDTH-1:0]  Run_Count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_core_rst;
  logic                  r_halted;
  logic                  r_timeout;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [CNT_WIDTH-1:0]  r_run_count;
  logic [CNT_WIDTH-1:0]  r_budget;

  logic                  w_accept;
  logic                  w_start_acc;
  logic                  w_halt_hit;
  logic                  w_budget_hit;
  logic                  w_addr_full;

  assign w_accept     = Load_Valid & (r_state == S_LOAD);
  assign w_start_acc  = Start & ((r_state == S_IDLE) | (r_state == S_HALT));
  assign w_halt_hit   = (Core_Instruction == HALT_INSTR);
  // The budget is hit on the last of Run_Cycles RUN cycles (count starts at 0).
  assign w_budget_hit = (r_budget != '0) && (r_run_count == (r_budget - CNT_WIDTH'(1)));
  assign w_addr_full  = (r_word_count[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});

  // Next-state decode and combinational load-port outputs.
  always_comb begin
    w_next     = r_state;
    Load_Ready = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_LOAD;
      end
      S_LOAD: begin
        Load_Ready = 1'b1;
        Busy       = 1'b1;
        if (Abort) w_next = S_IDLE;
        else if (w_accept && (Load_Last || w_addr_full)) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        Busy = 1'b1;
        if (Abort) w_next = S_IDLE;
        else       w_next = S_RUN;
      end
      S_RUN: begin
        Busy = 1'b1;
        if (Abort) w_next = S_IDLE;
        else if (w_halt_hit || w_budget_hit) w_next = S_HALT;
      end
      S_HALT: begin
        Done = 1'b1;
        if (Start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counters, end-of-run flags and the registered core reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_core_rst   <= 1'b0;
      r_halted     <= 1'b0;
      r_timeout    <= 1'b0;
      r_word_count <= '0;
      r_run_count  <= '0;
      r_budget     <= '0;
    end else begin
      r_state    <= w_next;
      // Core runs only while the sequencer will be in RUN next cycle.
      r_core_rst <= (w_next == S_RUN);
      if (w_start_acc) begin
        r_word_count <= '0;
        r_run_count  <= '0;
        r_halted     <= 1'b0;
        r_timeout    <= 1'b0;
        r_budget     <= Run_Cycles;
      end else begin
        if (w_accept) r_word_count <= r_word_count + (ADDR_WIDTH+1)'(1);
        if (r_state == S_RUN && r_run_count != {CNT_WIDTH{1'b1}})
          r_run_count <= r_run_count + CNT_WIDTH'(1);
        // Halt fetch wins over budget expiry when both land together.
        if (r_state == S_RUN && !Abort && w_next == S_HALT) begin
          r_halted  <= w_halt_hit;
          r_timeout <= ~w_halt_hit;
        end
      end
    end
  end

  assign IMem_WE    = w_accept;
  assign IMem_Addr  = r_word_count[ADDR_WIDTH-1:0];
  assign IMem_WData = Load_Data;
  assign Core_RST   = r_core_rst;
  assign Halted     = r_halted;
  assign Timeout    = r_timeout;
  assign Word_Count = r_word_count;
  assign Run_Count  = r_run_count;

endmodule
